pixel_coord_generator: RTL and testbench

- Raster-scan source that produces the (screen_x, screen_y, coords_valid) pixel stream consumed by the ray generation stage.
- Walks a SCREEN_WIDTH x SCREEN_HEIGHT frame row-major, from top-left (0,0) to bottom-right.
- Uses a valid/ready handshake so downstream pipeline stalls are honoured without losing or repeating pixels.
- Provides frame start/stop control, single-frame or continuous operation, and frame markers for the framebuffer writer.

---
 rtl/pixel_coord_generator.sv | 141 ++++++++++++++
 tb/tb_pixel_coord_generator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_coord_generator.sv
// pixel_coord_generator
//   Raster-scan source for the ray generation stage. Walks a
//   SCREEN_WIDTH x SCREEN_HEIGHT frame row-major from (0,0) to
//   (W-1,H-1) behind a valid/ready handshake, with frame markers.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle pulse, begins a frame when idle
//   continuous        restart automatically after the last pixel
//   abort             terminate the current frame (wins over start)
//   coords_ready      downstream accepts a beat this cycle
//   screen_x/y        raw integer pixel column/row, zero-extended to 32 bits
//   coords_valid      screen_x/screen_y carry a pixel
//   sof/eol/eof       first pixel / last of row / last of frame markers
//   busy              high while a frame is in progress
//   frame_count       frames fully accepted since reset (wraps)

`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

module pixel_coord_generator #(
    parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   abort,
    input  logic                   coords_ready,
    output logic [31:0]            screen_x,
    output logic [31:0]            screen_y,
    output logic                   coords_valid,
    output logic                   sof,
    output logic                   eol,
    output logic                   eof,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    // A 1-wide dimension would give $clog2 == 0; keep counters at least 1 bit.
    localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [XW-1:0]          x_reg, x_next;
    logic [YW-1:0]          y_reg, y_next;
    logic [FRAME_CNT_W-1:0] frame_count_reg, frame_count_next;

    logic in_run;
    logic xfer;
    logic last_x;
    logic last_y;

    assign in_run = (state_reg == RUN);
    assign xfer   = in_run && coords_ready;
    assign last_x = (x_reg == X_LAST);
    assign last_y = (y_reg == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            frame_count_reg <= frame_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        frame_count_next = frame_count_reg;

        case (state_reg)
            IDLE: begin
                // Coordinates are already parked at (0,0) whenever we are idle.
                if (start && !abort) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort discards the frame, including a same-cycle eof beat.
                    state_next = IDLE;
                    x_next     = '0;
                    y_next     = '0;
                end else if (xfer) begin
                    if (!last_x) begin
                        x_next = x_reg + 1'b1;
                    end else if (!last_y) begin
                        x_next = '0;
                        y_next = y_reg + 1'b1;
                    end else begin
                        x_next           = '0;
                        y_next           = '0;
                        frame_count_next = frame_count_reg + 1'b1;
                        if (!continuous) begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                x_next     = '0;
                y_next     = '0;
            end
        endcase
    end

    assign coords_valid = in_run;
    assign busy         = in_run;
    assign screen_x     = {{(32 - XW){1'b0}}, x_reg};
    assign screen_y     = {{(32 - YW){1'b0}}, y_reg};

    // Markers are qualified by valid so they read zero while idle.
    assign sof = in_run && (x_reg == '0) && (y_reg == '0);
    assign eol = in_run && last_x;
    assign eof = in_run && last_x && last_y;

    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_pixel_coord_generator.sv
module tb_pixel_coord_generator;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          abort = 1'b0;
    logic          coords_ready = 1'b0;
    logic [31:0]   screen_x;
    logic [31:0]   screen_y;
    logic          coords_valid;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic [FW-1:0] frame_count;

    int checks = 0;
    int errors = 0;

    pixel_coord_generator #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .FRAME_CNT_W  (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .abort       (abort),
        .coords_ready(coords_ready),
        .screen_x    (screen_x),
        .screen_y    (screen_y),
        .coords_valid(coords_valid),
        .sof         (sof),
        .eol         (eol),
        .eof         (eof),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit sof;
        bit eol;
        bit eof;
    } beat_t;

    beat_t exp_q[$];
    bit    model_run  = 1'b0;
    int    exp_frames = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A frame is simply every pixel in raster order with its markers.
    task automatic push_frame();
        beat_t b;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                b.x   = xx;
                b.y   = yy;
                b.sof = (xx == 0 && yy == 0);
                b.eol = (xx == W - 1);
                b.eof = (xx == W - 1 && yy == H - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Monitor and reference model: samples on the falling edge, where
    // inputs and outputs are both stable for the coming rising edge.
    initial begin
        beat_t hd;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                model_run  = 1'b0;
                exp_frames = 0;
            end else begin
                chk("coords_valid", int'(coords_valid), int'(model_run));
                chk("busy", int'(busy), int'(model_run));
                chk("frame_count", int'(frame_count), exp_frames % (1 << FW));
                if (model_run && coords_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        hd = exp_q[0];
                        chk("screen_x", int'(screen_x), hd.x);
                        chk("screen_y", int'(screen_y), hd.y);
                        chk("sof", int'(sof), int'(hd.sof));
                        chk("eol", int'(eol), int'(hd.eol));
                        chk("eof", int'(eof), int'(hd.eof));
                        $display("beat x=%0d y=%0d sof=%0b eol=%0b eof=%0b ready=%0b",
                                 screen_x, screen_y, sof, eol, eof, coords_ready);
                    end
                end else if (!model_run) begin
                    chk("idle_x", int'(screen_x), 0);
                    chk("idle_y", int'(screen_y), 0);
                    chk("idle_flags", int'({sof, eol, eof}), 0);
                end

                if (!model_run) begin
                    if (start && !abort) begin
                        model_run = 1'b1;
                        push_frame();
                    end
                end else if (abort) begin
                    model_run = 1'b0;
                    exp_q.delete();
                end else if (coords_ready && exp_q.size() > 0) begin
                    hd = exp_q.pop_front();
                    if (hd.eof) begin
                        exp_frames++;
                        if (continuous) push_frame();
                        else model_run = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit rnd_ready, input bit rnd_start);
        int n = 0;
        while (model_run && n < 2000) begin
            if (rnd_ready) coords_ready = ($urandom_range(0, 3) != 0);
            start = rnd_start && ($urandom_range(0, 7) == 0);
            step(1);
            n++;
        end
        start = 1'b0;
        if (model_run) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_pos(input string name, input int xx, input int yy);
        int n = 0;
        while (!(coords_valid && int'(screen_x) == xx && int'(screen_y) == yy) && n < 2000) begin
            step(1);
            n++;
        end
        if (n >= 2000) chk({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst_valid", int'(coords_valid), 0);
        chk("rst_count", int'(frame_count), 0);
        rst = 1'b0;
        step(2);

        // Single frame with ready held high.
        coords_ready = 1'b1;
        pulse_start();
        wait_idle("frame1", 1'b0, 1'b0);
        step(2);

        // Stall at (5,0), then random ready for the rest.
        pulse_start();
        wait_pos("stall", 5, 0);
        coords_ready = 1'b0;
        step(10);
        coords_ready = 1'b1;
        wait_idle("stall_frame", 1'b1, 1'b0);
        step(2);

        // Continuous over two frames, random ready and stray starts in RUN.
        coords_ready = 1'b1;
        continuous   = 1'b1;
        pulse_start();
        wait_pos("cont_second", 3, 0);
        step(W * H - 6);
        wait_pos("cont_second_b", 0, 1);
        continuous = 1'b0;
        wait_idle("cont_frames", 1'b1, 1'b1);
        step(2);

        // Abort mid-frame, then restart from (0,0).
        coords_ready = 1'b1;
        pulse_start();
        wait_pos("abort_pos", 5, 2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        step(2);
        pulse_start();
        wait_idle("after_abort", 1'b1, 1'b0);

        // Abort coincident with an eof transfer: frame not counted.
        coords_ready = 1'b1;
        continuous   = 1'b1;
        pulse_start();
        wait_pos("abort_eof", W - 1, H - 1);
        abort = 1'b1;
        step(1);
        abort      = 1'b0;
        continuous = 1'b0;
        step(2);

        // Start and abort together while idle: stays idle.
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        step(3);

        // Asynchronous reset mid-frame takes effect without a clock edge.
        pulse_start();
        step(6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", int'(coords_valid), 0);
        chk("arst_x", int'(screen_x), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(frame_count), 0);
        step(2);
        rst = 1'b0;
        step(2);
        pulse_start();
        wait_idle("post_reset", 1'b1, 1'b0);
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
